// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port synchronous-read data memory: IDLE/ISSUE/RESP access FSM.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with a MAX_BURST starvation guard.
module dmem_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]  state;
  logic        win;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        sel1;
  logic        any_req;
  logic        addr_err;
  logic        rd_ok;

  assign any_req  = p0_req | p1_req;
  assign addr_err = (|lat_addr[1:0]) | (|lat_addr[31:ADDR_W+2]);

`ifdef DMEM_ARB_RR_EN
  // prio names the port that wins the next tie; reset favours port 0.
  logic prio;

  assign sel1 = p1_req & (~p0_req | prio);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prio <= 1'b0;
    else if (state == IDLE && any_req)
      prio <= ~sel1;
  end
`else
  logic [3:0] burst_cnt;

  assign sel1 = p1_req & (~p0_req | (burst_cnt == 4'(MAX_BURST)));

  // Counts back-to-back port-0 wins only while port 1 is left waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      burst_cnt <= '0;
    else if (state == IDLE && any_req) begin
      if (sel1 || !p1_req)
        burst_cnt <= '0;
      else
        burst_cnt <= burst_cnt + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
    end else begin
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win       <= sel1;
            lat_we    <= sel1 ? p1_we    : p0_we;
            lat_addr  <= sel1 ? p1_addr  : p0_addr;
            lat_wdata <= sel1 ? p1_wdata : p0_wdata;
            p0_gnt    <= ~sel1;
            p1_gnt    <= sel1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          p0_rvalid <= ~win;
          p1_rvalid <= win;
          p0_err    <= ~win & addr_err;
          p1_err    <= win & addr_err;
          state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobe is decoded from state so an async reset kills it at once.
  assign mem_we   = (state == ISSUE) & lat_we & ~addr_err;
  assign mem_addr = lat_addr[ADDR_W+1:2];
  assign mem_wd   = lat_wdata;

  // Read data arrives from the array during RESP; pass it straight through.
  assign rd_ok    = (state == RESP) & ~lat_we & ~(p0_err | p1_err);
  assign p0_rdata = (rd_ok & ~win) ? mem_rd : 32'd0;
  assign p1_rdata = (rd_ok &  win) ? mem_rd : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous-read memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [32] = '{default: 32'd0};

  int nvec = 0;
  int nerr = 0;

  dmem_arbiter #(.ADDR_W(5), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
    mem_rd <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at an IDLE-cycle negedge, returns at the following IDLE-cycle negedge.
  task automatic xfer(input string tag, input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
    int n;
    logic [4:0] exp_ma;
    exp_ma = addr[6:2];
    if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(port ? p1_gnt : p0_gnt) && n < 10);
    chk({tag, "_gnt_lat"}, n, 1);
    chk({tag, "_other_gnt"}, port ? p0_gnt : p1_gnt, 0);
    chk({tag, "_mem_we"}, mem_we, we && !exp_err);
    if (!exp_err) chk({tag, "_mem_addr"}, mem_addr, exp_ma);
    if (we && !exp_err) chk({tag, "_mem_wd"}, mem_wd, wdata);
    if (port) p1_req = 0; else p0_req = 0;
    @(negedge clk);
    chk({tag, "_rvalid"}, port ? p1_rvalid : p0_rvalid, 1);
    chk({tag, "_other_rvalid"}, port ? p0_rvalid : p1_rvalid, 0);
    chk({tag, "_err"}, port ? p1_err : p0_err, exp_err);
    chk({tag, "_rdata"}, port ? p1_rdata : p0_rdata, exp_rd);
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [5:0] exp_seq;
    rst_n = 0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    #12;
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_errs", {p0_err, p1_err}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_rdata", p0_rdata | p1_rdata, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // Same-address conflict: p0 write and p1 read of 0x4 raised together.
    p0_req = 1; p0_we = 1; p0_addr = 32'h4; p0_wdata = 32'h1111_1111;
    p1_req = 1; p1_we = 0; p1_addr = 32'h4; p1_wdata = 0;
    @(negedge clk);
    chk("conf_p0_first", p0_gnt, 1);
    chk("conf_p1_waits", p1_gnt, 0);
    chk("conf_mem_we", mem_we, 1);
    p0_req = 0;
    @(negedge clk);
    chk("conf_p0_rvalid", p0_rvalid, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!p1_gnt && n < 10);
    chk("conf_p1_gnt_gap", n, 2);
    p1_req = 0;
    @(negedge clk);
    chk("conf_p1_rvalid", p1_rvalid, 1);
    chk("conf_p1_rdata", p1_rdata, 32'h1111_1111);
    @(negedge clk);

    xfer("p0_wr10", 0, 1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
    xfer("p0_rd10", 0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
    xfer("p1_wr12", 1, 1, 32'h12, 32'h5555_AAAA, 32'h0, 1);
    xfer("p1_rd10", 1, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
    xfer("p0_rd80", 0, 0, 32'h80, 32'h0, 32'h0, 1);
    xfer("p1_rd7c", 1, 0, 32'h7C, 32'h0, 32'h0, 0);

    // Reset dropped during the ISSUE cycle of a write.
    p0_req = 1; p0_we = 1; p0_addr = 32'h8; p0_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rmid_gnt", p0_gnt, 1);
    chk("rmid_mem_we_pre", mem_we, 1);
    #1 rst_n = 0;
    #1;
    chk("rmid_mem_we", mem_we, 0);
    chk("rmid_gnt_clr", p0_gnt, 0);
    chk("rmid_mem_addr", mem_addr, 0);
    chk("rmid_mem_wd", mem_wd, 0);
    p0_req = 0;
    @(negedge clk);
    chk("rmid_no_rvalid", {p0_rvalid, p1_rvalid}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rmid_no_rvalid2", {p0_rvalid, p1_rvalid}, 0);
    xfer("p1_rd8_after_rst", 1, 0, 32'h8, 32'h0, 32'h0, 0);

    // Both ports requesting continuously.
`ifdef DMEM_ARB_RR_EN
    exp_seq = 6'b101010;
`else
    exp_seq = 6'b010000;
`endif
    p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    p1_req = 1; p1_we = 0; p1_addr = 32'h4;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(p0_gnt || p1_gnt) && n < 10);
      chk($sformatf("seq%0d_timeout", g), n >= 10, 0);
      chk($sformatf("seq%0d_onehot", g), p0_gnt & p1_gnt, 0);
      chk($sformatf("seq%0d_port", g), p1_gnt, exp_seq[g]);
    end
    p0_req = 0; p1_req = 0;
    @(negedge clk);
    chk("seq_last_rvalid", {p1_rvalid, p0_rvalid}, exp_seq[5] ? 2'b10 : 2'b01);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
